ping_sequencer: RTL and testbench

- Sequences one transmit burst of N acoustic pings for the USBL transmitter.
- Each ping is shaped by an amplitude envelope: ramp up, hold at full scale, ramp down. Pings are separated by a silent guard interval.
- Drives the 8-bit amplitude word and the carrier enable consumed by the transmit datapath.
- Is itself driven by a start/abort control interface from the top-level controller.

---
 rtl/usbl_tx_pkg.sv | 24 ++
 rtl/ramp_step_timer.sv | 36 +++
 rtl/ping_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_ping_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbl_tx_pkg.sv
`default_nettype none
// ============================================================================
// usbl_tx_pkg : shared state type and constants for the USBL ping sequencer
// Rev 1.0
// ============================================================================
package usbl_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_GUARD     = 3'd4
  } seq_state_e;

  localparam int c_len_w_default    = 16;
  localparam int c_prescale_default = 256;

  function automatic int amp_max(input int ramp_w);
    return (1 << ramp_w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_step_timer.sv
`default_nettype none
// ============================================================================
// ramp_step_timer : one-cycle tick every PRESCALE enabled cycles, cleared on
//                   every state entry so each ramp starts on a fresh period.
// Rev 1.0
// ============================================================================
module ramp_step_timer #(
  parameter int PRESCALE = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int                 c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  assign tick = en && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ping_sequencer.sv
`default_nettype none
// ============================================================================
// ping_sequencer : burst of enveloped acoustic pings (ramp up, hold, ramp
//                  down, guard) with graceful abort for the USBL transmitter.
// Rev 1.0
// ============================================================================
module ping_sequencer
  import usbl_tx_pkg::*;
#(
  parameter int RAMP_W   = 8,
  parameter int LEN_W    = c_len_w_default,
  parameter int PRESCALE = c_prescale_default
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  cfg_hold_len,
  input  logic [LEN_W-1:0]  cfg_guard_len,
  input  logic [7:0]        cfg_count,
  output logic              busy,
  output logic              tx_en,
  output logic [RAMP_W-1:0] amp,
  output logic              ping_done,
  output logic              burst_done,
  output logic              aborted
);

  localparam logic [RAMP_W-1:0] c_amp_max = RAMP_W'(amp_max(RAMP_W));
  localparam logic [RAMP_W-1:0] c_amp_one = RAMP_W'(1);
  localparam logic [LEN_W-1:0]  c_len_one = LEN_W'(1);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [RAMP_W-1:0] r_amp;
  logic [RAMP_W-1:0] w_amp_nxt;
  logic [LEN_W-1:0]  r_hold_len;
  logic [LEN_W-1:0]  r_guard_len;
  logic [LEN_W-1:0]  r_len_cnt;
  logic [LEN_W-1:0]  w_len_target;
  logic [7:0]        r_pings_left;
  logic              r_abort_pend;
  logic              r_busy;
  logic              r_tx_en;
  logic              r_ping_done;
  logic              r_burst_done;
  logic              r_aborted;
  logic              w_abort;
  logic              w_tick;
  logic              w_entry;
  logic              w_ramp;
  logic              w_len_last;
  logic              w_load_cfg;
  logic              w_ping_end;
  logic              w_burst_end;
  logic              w_end_aborted;

  assign w_abort      = abort || r_abort_pend;
  assign w_entry      = (w_state_nxt != r_state);
  assign w_ramp       = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
  assign w_len_target = (r_state == ST_HOLD) ? r_hold_len : r_guard_len;
  assign w_len_last   = (r_len_cnt == (w_len_target - c_len_one));

  ramp_step_timer #(
    .PRESCALE (PRESCALE)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_entry),
    .en   (w_ramp),
    .tick (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_amp_nxt     = r_amp;
    w_load_cfg    = 1'b0;
    w_ping_end    = 1'b0;
    w_burst_end   = 1'b0;
    w_end_aborted = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RAMP_UP;
          w_amp_nxt   = '0;
          w_load_cfg  = 1'b1;
        end
      end
      ST_RAMP_UP: begin
        // Abort wins over a coincident step: ramp down from the amp on air now.
        if (w_abort) begin
          if (r_amp == '0) begin
            w_state_nxt   = ST_IDLE;
            w_burst_end   = 1'b1;
            w_end_aborted = 1'b1;
          end else begin
            w_state_nxt = ST_RAMP_DOWN;
          end
        end else if (w_tick) begin
          if (r_amp >= (c_amp_max - c_amp_one)) begin
            w_amp_nxt   = c_amp_max;
            w_state_nxt = ST_HOLD;
          end else begin
            w_amp_nxt = r_amp + c_amp_one;
          end
        end
      end
      ST_HOLD: begin
        if (w_abort || w_len_last) begin
          w_state_nxt = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (w_tick) begin
          if (r_amp > c_amp_one) begin
            w_amp_nxt = r_amp - c_amp_one;
          end else begin
            w_amp_nxt  = '0;
            w_ping_end = 1'b1;
            if (w_abort || (r_pings_left <= 8'd1)) begin
              w_state_nxt   = ST_IDLE;
              w_burst_end   = 1'b1;
              w_end_aborted = w_abort;
            end else begin
              w_state_nxt = ST_GUARD;
            end
          end
        end
      end
      ST_GUARD: begin
        if (w_abort) begin
          w_state_nxt   = ST_IDLE;
          w_burst_end   = 1'b1;
          w_end_aborted = 1'b1;
        end else if (w_len_last) begin
          w_state_nxt = ST_RAMP_UP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_amp_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_amp        <= '0;
      r_hold_len   <= '0;
      r_guard_len  <= '0;
      r_len_cnt    <= '0;
      r_pings_left <= '0;
      r_abort_pend <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_en      <= 1'b0;
      r_ping_done  <= 1'b0;
      r_burst_done <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_amp        <= w_amp_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_tx_en      <= (w_state_nxt == ST_RAMP_UP) || (w_state_nxt == ST_HOLD) ||
                      (w_state_nxt == ST_RAMP_DOWN);
      r_ping_done  <= w_ping_end;
      r_burst_done <= w_burst_end;
      r_aborted    <= w_end_aborted;
      // Abort requests are remembered only inside a burst; in IDLE they are dropped.
      r_abort_pend <= w_abort && (r_state != ST_IDLE) && (w_state_nxt != ST_IDLE);

      if (w_entry) begin
        r_len_cnt <= '0;
      end else if ((r_state == ST_HOLD) || (r_state == ST_GUARD)) begin
        r_len_cnt <= r_len_cnt + c_len_one;
      end

      if (w_load_cfg) begin
        r_hold_len   <= (cfg_hold_len  == '0) ? c_len_one : cfg_hold_len;
        r_guard_len  <= (cfg_guard_len == '0) ? c_len_one : cfg_guard_len;
        r_pings_left <= (cfg_count     == '0) ? 8'd1      : cfg_count;
      end else if (w_ping_end) begin
        r_pings_left <= r_pings_left - 8'd1;
      end
    end
  end

  assign busy       = r_busy;
  assign tx_en      = r_tx_en;
  assign amp        = r_amp;
  assign ping_done  = r_ping_done;
  assign burst_done = r_burst_done;
  assign aborted    = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_ping_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ping_sequencer : cycle-by-cycle comparison against an envelope waveform
//                     model built from phase durations and abort rules.
// Rev 1.0
// ============================================================================
module tb_ping_sequencer;

  localparam int RW   = 4;
  localparam int PS   = 2;
  localparam int LW   = 16;
  localparam int AMAX = 15;

  localparam int PH_IDLE  = 0;
  localparam int PH_UP    = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_DOWN  = 3;
  localparam int PH_GUARD = 4;

  typedef struct packed {
    logic          busy;
    logic          tx_en;
    logic [RW-1:0] amp;
    logic          pd;
    logic          bd;
    logic          ab;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_hold_len = '0;
  logic [LW-1:0] cfg_guard_len = '0;
  logic [7:0]    cfg_count = '0;
  logic          busy;
  logic          tx_en;
  logic [RW-1:0] amp;
  logic          ping_done;
  logic          burst_done;
  logic          aborted;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];
  int   ph_q[$];

  ping_sequencer #(
    .RAMP_W   (RW),
    .LEN_W    (LW),
    .PRESCALE (PS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_hold_len  (cfg_hold_len),
    .cfg_guard_len (cfg_guard_len),
    .cfg_count     (cfg_count),
    .busy          (busy),
    .tx_en         (tx_en),
    .amp           (amp),
    .ping_done     (ping_done),
    .burst_done    (burst_done),
    .aborted       (aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("busy=%0b tx_en=%0b amp=%0d ping_done=%0b burst_done=%0b aborted=%0b",
                     o.busy, o.tx_en, o.amp, o.pd, o.bd, o.ab);
  endfunction

  function automatic void push(input int ph, input bit b, input bit t, input int a,
                               input bit p, input bit d, input bit x);
    obs_t e;
    e.busy  = b;
    e.tx_en = t;
    e.amp   = RW'(a);
    e.pd    = p;
    e.bd    = d;
    e.ab    = x;
    exp_q.push_back(e);
    ph_q.push_back(ph);
  endfunction

  function automatic void trunc(input int n);
    while (exp_q.size() > n) begin
      void'(exp_q.pop_back());
      void'(ph_q.pop_back());
    end
  endfunction

  // Expected outputs for cycles 1.. after the start edge, ending on the burst_done cycle.
  function automatic void build_expected(input int hold, input int guard, input int count,
                                         input int abort_at);
    int h, g, c, j, v, k;
    h = (hold  == 0) ? 1 : hold;
    g = (guard == 0) ? 1 : guard;
    c = (count == 0) ? 1 : count;
    exp_q.delete();
    ph_q.delete();
    for (int p = 0; p < c; p++) begin
      if (p > 0)
        for (int i = 0; i < g; i++) push(PH_GUARD, 1, 0, 0, (i == 0), 0, 0);
      for (int i = 0; i < AMAX * PS; i++) push(PH_UP, 1, 1, i / PS, 0, 0, 0);
      for (int i = 0; i < h; i++) push(PH_HOLD, 1, 1, AMAX, 0, 0, 0);
      for (int i = 0; i < AMAX * PS; i++) push(PH_DOWN, 1, 1, AMAX - i / PS, 0, 0, 0);
    end
    push(PH_IDLE, 0, 0, 0, 1, 1, 0);
    if (abort_at > 0 && abort_at < exp_q.size()) begin
      j = abort_at - 1;
      v = int'(exp_q[j].amp);
      if (ph_q[j] == PH_DOWN) begin
        k = j;
        while (ph_q[k + 1] == PH_DOWN) k++;
        trunc(k + 1);
        push(PH_IDLE, 0, 0, 0, 1, 1, 1);
      end else if (ph_q[j] == PH_GUARD || v == 0) begin
        trunc(j + 1);
        push(PH_IDLE, 0, 0, 0, 0, 1, 1);
      end else begin
        trunc(j + 1);
        for (int i = 0; i < v * PS; i++) push(PH_DOWN, 1, 1, v - i / PS, 0, 0, 0);
        push(PH_IDLE, 0, 0, 0, 1, 1, 1);
      end
    end
  endfunction

  // Starts one burst, checks every cycle, and scrambles start/config while busy.
  task automatic run_burst(input string name, input int hold, input int guard, input int count,
                           input int abort_at, input bit abort_with_start);
    obs_t got;
    build_expected(hold, guard, count, abort_at);
    @(negedge clk);
    got = {busy, tx_en, amp, ping_done, burst_done, aborted};
    n_tests++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL %s idle_before_start: got %s, want all zero", name, fmt(got));
    end
    cfg_hold_len  = LW'(hold);
    cfg_guard_len = LW'(guard);
    cfg_count     = 8'(count);
    start         = 1'b1;
    abort         = abort_with_start;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      got = {busy, tx_en, amp, ping_done, burst_done, aborted};
      n_tests++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %s, want %s", name, i + 1, fmt(got), fmt(exp_q[i]));
      end
      start = exp_q[i].busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      abort = (i + 1 == abort_at);
      if (exp_q[i].busy) begin
        cfg_hold_len  = LW'($urandom_range(0, 40));
        cfg_guard_len = LW'($urandom_range(0, 40));
        cfg_count     = 8'($urandom_range(0, 5));
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    rst   = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    got = {busy, tx_en, amp, ping_done, burst_done, aborted};
    n_tests++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state: got %s, want all zero", fmt(got));
    end
    start = 1'b0;
    rst   = 1'b1;
  endtask

  task automatic test_single_ping();
    run_burst("single_ping", 5, 10, 1, 0, 1'b0);
  endtask

  task automatic test_burst();
    run_burst("burst_two", 5, 10, 2, 0, 1'b0);
  endtask

  task automatic test_zero_cfg();
    run_burst("zero_cfg", 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_abort_hold();
    run_burst("abort_hold", 5, 10, 1, 32, 1'b0);
  endtask

  task automatic test_abort_entry();
    run_burst("abort_entry", 5, 10, 3, 1, 1'b0);
  endtask

  task automatic test_abort_ramp_up();
    run_burst("abort_ramp_up", 4, 6, 2, 13, 1'b0);
  endtask

  task automatic test_abort_guard();
    run_burst("abort_guard", 2, 5, 2, 64, 1'b0);
  endtask

  task automatic test_start_with_abort();
    run_burst("start_with_abort", 3, 4, 1, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_burst("back_to_back_a", 1, 2, 1, 0, 1'b0);
    run_burst("back_to_back_b", 2, 1, 2, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    obs_t got;
    obs_t want;
    @(negedge clk);
    cfg_hold_len  = LW'(5);
    cfg_guard_len = LW'(3);
    cfg_count     = 8'd2;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    want = {1'b1, 1'b1, RW'(8 / PS), 1'b0, 1'b0, 1'b0};
    got  = {busy, tx_en, amp, ping_done, burst_done, aborted};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %s, want %s", fmt(got), fmt(want));
    end
    #2 rst = 1'b0;
    #1 got = {busy, tx_en, amp, ping_done, burst_done, aborted};
    n_tests++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %s, want all zero", fmt(got));
    end
    @(negedge clk);
    got = {busy, tx_en, amp, ping_done, burst_done, aborted};
    n_tests++;
    if (got !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_mid_held: got %s, want all zero", fmt(got));
    end
    rst = 1'b1;
    run_burst("after_reset", 5, 10, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int h, g, c, a;
    for (int r = 0; r < 8; r++) begin
      h = $urandom_range(0, 12);
      g = $urandom_range(0, 12);
      c = $urandom_range(0, 3);
      a = 0;
      if (r % 2 == 1) begin
        build_expected(h, g, c, 0);
        a = $urandom_range(1, exp_q.size() - 1);
      end
      run_burst($sformatf("random_%0d", r), h, g, c, a, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_ping();
    test_burst();
    test_zero_cfg();
    test_abort_hold();
    test_abort_entry();
    test_abort_ramp_up();
    test_abort_guard();
    test_start_with_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
